// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores as two 16-bit half accesses onto an
// external asynchronous SRAM, followed by a programmable idle pad.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_read,
  input  logic        MEM_write,
  input  logic [31:0] Add,
  input  logic [31:0] input_data,
  output logic [31:0] out_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  // state  | meaning
  // S_IDLE | no access; waits for MEM_read/MEM_write
  // S_LO   | low half-word cycle at {widx,0}
  // S_HI   | high half-word cycle at {widx,1}
  // S_WAIT | idle pad, counter runs down to 0
  // S_DONE | ready for one cycle, pipeline advances
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] out_data_q, out_data_d;
  logic        is_wr_q, is_wr_d;
  logic        req;
  logic        bus_wr;
  logic [16:0] req_widx;

  assign req      = MEM_read | MEM_write;
  // Out-of-range addresses intentionally wrap modulo 2^17 words.
  assign req_widx = 17'((Add - 32'(BASE_ADDR)) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      widx_q     <= 17'd0;
      wdata_q    <= 32'd0;
      out_data_q <= 32'd0;
      is_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      out_data_q <= out_data_d;
      is_wr_q    <= is_wr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    out_data_d = out_data_q;
    is_wr_d    = is_wr_q;
    ready      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          widx_d  = req_widx;
          wdata_d = input_data;
          is_wr_d = MEM_write;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (!is_wr_q) out_data_d[15:0] = SRAM_DQ;
        state_d = S_HI;
      end
      S_HI: begin
        if (!is_wr_q) out_data_d[31:16] = SRAM_DQ;
        if (WAIT_CYCLES == 0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = WAIT_LAST;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The bus is only ever driven during the two half cycles of a write.
  assign bus_wr    = is_wr_q && ((state_q == S_LO) || (state_q == S_HI));
  assign SRAM_WE_N = ~bus_wr;
  assign SRAM_OE_N = bus_wr;
  assign SRAM_ADDR = {widx_q, (state_q == S_HI)};
  assign SRAM_DQ   = bus_wr ? ((state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a W=2 instance and a W=0 instance, each with its
// own async SRAM model, checked against a word-level memory reference.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_rd, a_wr, a_rdy, a_we, a_oe, a_ce, a_ub, a_lb;
  logic [31:0] a_add, a_wd, a_od;
  logic [17:0] a_addr;
  wire  [15:0] a_dq;
  logic        b_rd, b_wr, b_rdy, b_we, b_oe, b_ce, b_ub, b_lb;
  logic [31:0] b_add, b_wd, b_od;
  logic [17:0] b_addr;
  wire  [15:0] b_dq;

  logic [15:0] memA [0:262143];
  logic [15:0] memB [0:262143];

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_n), .MEM_read(a_rd), .MEM_write(a_wr), .Add(a_add),
    .input_data(a_wd), .out_data(a_od), .ready(a_rdy), .SRAM_DQ(a_dq),
    .SRAM_ADDR(a_addr), .SRAM_WE_N(a_we), .SRAM_OE_N(a_oe),
    .SRAM_CE_N(a_ce), .SRAM_UB_N(a_ub), .SRAM_LB_N(a_lb));

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_n), .MEM_read(b_rd), .MEM_write(b_wr), .Add(b_add),
    .input_data(b_wd), .out_data(b_od), .ready(b_rdy), .SRAM_DQ(b_dq),
    .SRAM_ADDR(b_addr), .SRAM_WE_N(b_we), .SRAM_OE_N(b_oe),
    .SRAM_CE_N(b_ce), .SRAM_UB_N(b_ub), .SRAM_LB_N(b_lb));

  // Asynchronous SRAM models: drive on OE while not writing, capture on WE.
  assign a_dq = (!a_oe && a_we) ? memA[a_addr] : 16'bz;
  assign b_dq = (!b_oe && b_we) ? memB[b_addr] : 16'bz;
  always @(posedge clk) if (!a_we) memA[a_addr] <= a_dq;
  always @(posedge clk) if (!b_we) memB[b_addr] <= b_dq;

  int passed = 0;
  int total  = 0;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_out;
  int unsigned written [$];

  function automatic int unsigned widx_of(input logic [31:0] add);
    logic [31:0] off;
    off = add - 32'd1024;
    return (off >> 2) & 32'h1FFFF;
  endfunction

  task automatic access_a(input logic wr, input logic rd, input logic [31:0] add,
                          input logic [31:0] wd, output int freeze, output logic [31:0] od);
    freeze = 0;
    @(negedge clk);
    a_wr = wr; a_rd = rd; a_add = add; a_wd = wd;
    #1;
    while (!a_rdy && freeze < 40) begin
      freeze++;
      @(negedge clk); #1;
    end
    od = a_od;
    a_wr = 1'b0; a_rd = 1'b0;
    if (wr) ref_mem[widx_of(add)] = wd;
    else if (rd) ref_out = ref_mem[widx_of(add)];
  endtask

  task automatic access_b(input logic wr, input logic [31:0] add, input logic [31:0] wd,
                          output int freeze, output logic [31:0] od);
    freeze = 0;
    @(negedge clk);
    b_wr = wr; b_rd = ~wr; b_add = add; b_wd = wd;
    #1;
    while (!b_rdy && freeze < 40) begin
      freeze++;
      @(negedge clk); #1;
    end
    od = b_od;
    b_wr = 1'b0; b_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_rd = 0; a_wr = 0; a_add = 0; a_wd = 0;
    b_rd = 0; b_wr = 0; b_add = 0; b_wd = 0;
    ref_out = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (a_od !== 32'd0) $display("FAIL reset_out_data got=%h exp=0", a_od); else passed++;
    total++; if (a_we !== 1'b1 || a_oe !== 1'b0) $display("FAIL reset_we_oe got=%b%b exp=10", a_we, a_oe); else passed++;
    total++; if (a_addr !== 18'd0) $display("FAIL reset_addr got=%h exp=0", a_addr); else passed++;
    total++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) $display("FAIL reset_ready got=%b%b exp=11", a_rdy, b_rdy); else passed++;
    total++; if ({a_ce, a_ub, a_lb} !== 3'b000) $display("FAIL reset_ce_ub_lb got=%b exp=000", {a_ce, a_ub, a_lb}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int f; logic [31:0] od;
    access_a(1, 0, 32'd1024, 32'hDEADBEEF, f, od);
    total++; if (f != 5) $display("FAIL wr_freeze got=%0d exp=5", f); else passed++;
    total++; if (memA[0] !== 16'hBEEF || memA[1] !== 16'hDEAD)
      $display("FAIL wr_halves got=%h_%h exp=dead_beef", memA[1], memA[0]); else passed++;
    total++; if (od !== 32'd0) $display("FAIL wr_out_unchanged got=%h exp=0", od); else passed++;
    access_a(0, 1, 32'd1024, 32'h0, f, od);
    total++; if (f != 5) $display("FAIL rd_freeze got=%0d exp=5", f); else passed++;
    total++; if (od !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", od); else passed++;
    written.push_back(0);
  endtask

  task automatic test_mapping();
    int f; logic [31:0] od;
    access_a(1, 0, 32'd1036, 32'h12345678, f, od);
    total++; if (memA[6] !== 16'h5678 || memA[7] !== 16'h1234)
      $display("FAIL map_halves got=%h_%h exp=1234_5678", memA[7], memA[6]); else passed++;
    access_a(0, 1, 32'd1024, 32'h0, f, od);
    total++; if (od !== 32'hDEADBEEF) $display("FAIL map_rd0 got=%h exp=deadbeef", od); else passed++;
    access_a(0, 1, 32'd1036, 32'h0, f, od);
    total++; if (od !== 32'h12345678) $display("FAIL map_rd3 got=%h exp=12345678", od); else passed++;
    written.push_back(3);
  endtask

  task automatic test_wrap();
    int f; logic [31:0] od;
    access_a(1, 0, 32'd1024 + 32'd524288, 32'hA5A5A5A5, f, od);
    total++; if (memA[0] !== 16'hA5A5 || memA[1] !== 16'hA5A5)
      $display("FAIL wrap_halves got=%h_%h exp=a5a5_a5a5", memA[1], memA[0]); else passed++;
    access_a(0, 1, 32'd1024, 32'h0, f, od);
    total++; if (od !== 32'hA5A5A5A5) $display("FAIL wrap_rd got=%h exp=a5a5a5a5", od); else passed++;
  endtask

  task automatic test_both();
    int f; logic [31:0] od; logic [31:0] prev;
    prev = ref_out;
    access_a(1, 1, 32'd1044, 32'h0F0F0F0F, f, od);
    total++; if (od !== prev) $display("FAIL both_out_unchanged got=%h exp=%h", od, prev); else passed++;
    total++; if (memA[10] !== 16'h0F0F || memA[11] !== 16'h0F0F)
      $display("FAIL both_written got=%h_%h exp=0f0f_0f0f", memA[11], memA[10]); else passed++;
    total++; if (f != 5) $display("FAIL both_freeze got=%0d exp=5", f); else passed++;
    written.push_back(5);
  endtask

  task automatic test_random();
    int f; logic [31:0] od; logic [31:0] add; logic [31:0] d; int unsigned w;
    int errs = 0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        w = $urandom_range(0, 31);
        add = 32'd1024 + 32'(w) * 4 + (($urandom_range(0, 3) == 0) ? 32'd524288 : 32'd0);
        d = $urandom;
        access_a(1, 0, add, d, f, od);
        written.push_back(w);
        total++; if ({memA[2*w+1], memA[2*w]} !== ref_mem[w])
          $display("FAIL rand_wr[%0d] got=%h exp=%h", i, {memA[2*w+1], memA[2*w]}, ref_mem[w]); else passed++;
      end else begin
        w = written[$urandom_range(0, written.size() - 1)];
        add = 32'd1024 + 32'(w) * 4;
        access_a(0, 1, add, 32'h0, f, od);
        total++; if (od !== ref_mem[w]) $display("FAIL rand_rd[%0d] got=%h exp=%h", i, od, ref_mem[w]); else passed++;
      end
      if (f != 5) errs++;
    end
    total++; if (errs != 0) $display("FAIL rand_freeze got=%0d bad latencies exp=0", errs); else passed++;
  endtask

  task automatic test_wait0();
    int f1, f2; logic [31:0] od1, od2;
    access_b(1, 32'd1024, 32'h11112222, f1, od1);
    access_b(1, 32'd1028, 32'h33334444, f1, od1);
    total++; if (f1 != 3) $display("FAIL w0_wr_freeze got=%0d exp=3", f1); else passed++;
    access_b(0, 32'd1024, 32'h0, f1, od1);
    access_b(0, 32'd1028, 32'h0, f2, od2);
    total++; if (f1 + 1 + f2 + 1 != 8) $display("FAIL w0_b2b_cycles got=%0d exp=8", f1 + f2 + 2); else passed++;
    total++; if (od1 !== 32'h11112222 || od2 !== 32'h33334444)
      $display("FAIL w0_b2b_data got=%h,%h exp=11112222,33334444", od1, od2); else passed++;
  endtask

  task automatic test_reset_mid();
    int f; logic [31:0] od; logic [15:0] old9;
    old9 = memA[9];
    @(negedge clk);
    a_wr = 1'b1; a_rd = 1'b0; a_add = 32'd1040; a_wd = 32'hCAFEBABE;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if (a_we !== 1'b0 || a_addr !== 18'd9)
      $display("FAIL mid_in_hi got=we%b addr%0d exp=we0 addr9", a_we, a_addr); else passed++;
    rst_n = 1'b0; a_wr = 1'b0;
    #1;
    total++; if (a_od !== 32'd0 || a_we !== 1'b1 || a_rdy !== 1'b1)
      $display("FAIL mid_reset got=od%h we%b rdy%b exp=od0 we1 rdy1", a_od, a_we, a_rdy); else passed++;
    total++; if (memA[8] !== 16'hBABE || memA[9] !== old9)
      $display("FAIL mid_partial got=%h_%h exp=%h_babe", memA[9], memA[8], old9); else passed++;
    @(negedge clk); rst_n = 1'b1;
    ref_mem[4] = {old9, 16'hBABE};
    ref_out = 32'd0;
    access_a(0, 1, 32'd1040, 32'h0, f, od);
    total++; if (od !== {old9, 16'hBABE}) $display("FAIL mid_readback got=%h exp=%h", od, {old9, 16'hBABE}); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mapping();
    test_wrap();
    test_both();
    test_random();
    test_wait0();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
